// File: rtl/dispatch_credit_ctrl.sv
// dispatch_credit_ctrl: dispatch-stage credit controller.
// Tracks free reservation-station entries (ALU, branch, aux unit) and ROB
// occupancy, decides per cycle whether the decoded instruction dispatches,
// and hands out the ROB tail as the instruction's tag.
// Optional feature macro: DISPATCH_STATS_EN adds stallCycles/robFullCycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RUN   | normal operation, dispatch allowed when resources permit
// S_FLUSH | one recovery cycle after flush; no dispatch, credits full

// One reservation-station credit counter: DEPTH free entries at reset.
module dispatch_credit_cnt #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restore_i,
    input  logic alloc_i,
    input  logic free_i,
    output logic avail_o,
    output logic err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] cred_q;
    logic [CW-1:0] cred_d;

    assign avail_o = (cred_q != '0);
    // A release at a full counter is an error unless an allocation in the
    // same cycle makes room for it.
    assign err_o   = free_i & ~alloc_i & (cred_q == FULL);

    // Next credit value: restore wins, simultaneous alloc/free cancel.
    always_comb begin
        cred_d = cred_q;
        if (restore_i) begin
            cred_d = FULL;
        end else if (alloc_i && !free_i) begin
            cred_d = cred_q - CW'(1);
        end else if (free_i && !alloc_i && (cred_q != FULL)) begin
            cred_d = cred_q + CW'(1);
        end
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cred_q <= FULL;
        end else begin
            cred_q <= cred_d;
        end
    end
endmodule

module dispatch_credit_ctrl #(
    parameter int ALU_DEPTH = 4,
    parameter int BR_DEPTH  = 4,
    parameter int AUX_DEPTH = 4,
    parameter int ROB_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         decValid,
    input  logic [1:0]                   RSstation,
    input  logic                         stationRequest,
    input  logic                         robWrite,
    input  logic                         aluFree,
    input  logic                         brFree,
    input  logic                         auxFree,
    input  logic                         robCommit,
    input  logic                         flush,
    output logic                         dispatch,
    output logic                         decStall,
    output logic [$clog2(ROB_DEPTH)-1:0] robTag,
    output logic                         creditErr
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                  stallCycles,
    output logic [31:0]                  robFullCycles
`endif
);
    localparam int TW   = $clog2(ROB_DEPTH);
    localparam int CNTW = $clog2(ROB_DEPTH + 1);
    localparam logic [CNTW-1:0] ROB_FULL = CNTW'(ROB_DEPTH);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t          state_q;
    logic [TW-1:0]   rob_head_q;
    logic [TW-1:0]   rob_tail_q;
    logic [CNTW-1:0] rob_cnt_q;
    logic            err_q;

    logic need_rs;
    logic sel_alu, sel_br, sel_aux;
    logic alu_avail, br_avail, aux_avail;
    logic alu_err, br_err, aux_err;
    logic rs_ok, rob_ok, run, discard;
    logic rob_alloc, rob_commit, rob_err;

    assign need_rs = stationRequest & (RSstation != 2'b10);
    assign sel_alu = (RSstation == 2'b00);
    assign sel_br  = (RSstation == 2'b01);
    assign sel_aux = (RSstation == 2'b11);
    assign run     = (state_q == S_RUN);
    // Releases and commits are dropped while recovering; credits are being
    // rebuilt from scratch in those cycles.
    assign discard = flush | ~run;

    assign rs_ok  = ~need_rs | (sel_alu & alu_avail) | (sel_br & br_avail)
                  | (sel_aux & aux_avail);
    assign rob_ok = ~robWrite | (rob_cnt_q != ROB_FULL);

    assign dispatch = decValid & run & ~flush & ~reset & rs_ok & rob_ok;
    assign decStall = decValid & ~dispatch;
    assign robTag   = rob_tail_q;
    assign creditErr = err_q;

    assign rob_alloc  = dispatch & robWrite;
    assign rob_commit = robCommit & ~discard & (rob_cnt_q != '0);
    assign rob_err    = robCommit & ~discard & (rob_cnt_q == '0);

    dispatch_credit_cnt #(.DEPTH(ALU_DEPTH)) u_alu_cred (
        .clk       (clk),
        .reset     (reset),
        .restore_i (flush),
        .alloc_i   (dispatch & need_rs & sel_alu),
        .free_i    (aluFree & ~discard),
        .avail_o   (alu_avail),
        .err_o     (alu_err)
    );

    dispatch_credit_cnt #(.DEPTH(BR_DEPTH)) u_br_cred (
        .clk       (clk),
        .reset     (reset),
        .restore_i (flush),
        .alloc_i   (dispatch & need_rs & sel_br),
        .free_i    (brFree & ~discard),
        .avail_o   (br_avail),
        .err_o     (br_err)
    );

    dispatch_credit_cnt #(.DEPTH(AUX_DEPTH)) u_aux_cred (
        .clk       (clk),
        .reset     (reset),
        .restore_i (flush),
        .alloc_i   (dispatch & need_rs & sel_aux),
        .free_i    (auxFree & ~discard),
        .avail_o   (aux_avail),
        .err_o     (aux_err)
    );

    // Run/flush FSM together with ROB pointers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            rob_head_q <= '0;
            rob_tail_q <= '0;
            rob_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_q | alu_err | br_err | aux_err | rob_err;
            if (flush) begin
                state_q    <= S_FLUSH;
                rob_tail_q <= rob_head_q;
                rob_cnt_q  <= '0;
            end else if (state_q == S_FLUSH) begin
                state_q <= S_RUN;
            end else begin
                if (rob_alloc) begin
                    rob_tail_q <= rob_tail_q + TW'(1);
                end
                if (rob_commit) begin
                    rob_head_q <= rob_head_q + TW'(1);
                end
                case ({rob_alloc, rob_commit})
                    2'b10:   rob_cnt_q <= rob_cnt_q + CNTW'(1);
                    2'b01:   rob_cnt_q <= rob_cnt_q - CNTW'(1);
                    default: rob_cnt_q <= rob_cnt_q;
                endcase
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] full_cnt_q;

    assign stallCycles   = stall_cnt_q;
    assign robFullCycles = full_cnt_q;

    // Saturating event counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            if (decStall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((rob_cnt_q == ROB_FULL) && (full_cnt_q != 32'hFFFF_FFFF)) begin
                full_cnt_q <= full_cnt_q + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Testbench for dispatch_credit_ctrl: directed scenarios followed by random
// traffic, checked through an expected-response queue against a
// behavioural model of credits and ROB occupancy.
module tb_dispatch_credit_ctrl;
    localparam int ALU_D = 4;
    localparam int BR_D  = 4;
    localparam int AUX_D = 4;
    localparam int ROB_D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, decValid, stationRequest, robWrite;
    logic       aluFree, brFree, auxFree, robCommit, flush;
    logic [1:0] RSstation;
    logic       dispatch, decStall, creditErr;
    logic [2:0] robTag;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stallCycles, robFullCycles;
`endif

    dispatch_credit_ctrl #(
        .ALU_DEPTH(ALU_D), .BR_DEPTH(BR_D), .AUX_DEPTH(AUX_D), .ROB_DEPTH(ROB_D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .decValid       (decValid),
        .RSstation      (RSstation),
        .stationRequest (stationRequest),
        .robWrite       (robWrite),
        .aluFree        (aluFree),
        .brFree         (brFree),
        .auxFree        (auxFree),
        .robCommit      (robCommit),
        .flush          (flush),
        .dispatch       (dispatch),
        .decStall       (decStall),
        .robTag         (robTag),
        .creditErr      (creditErr)
`ifdef DISPATCH_STATS_EN
        ,
        .stallCycles    (stallCycles),
        .robFullCycles  (robFullCycles)
`endif
    );

    typedef struct {
        bit     disp;
        bit     stall;
        int     tag;
        bit     err;
        longint stall_n;
        longint full_n;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: free-entry counts per station and ROB as head+count.
    int     cred[3];
    int     dep[3];
    int     head, count;
    bit     err, in_flush;
    longint m_stall, m_full;

    task automatic model_reset();
        dep[0] = ALU_D; dep[1] = BR_D; dep[2] = AUX_D;
        for (int i = 0; i < 3; i++) cred[i] = dep[i];
        head = 0; count = 0; err = 0; in_flush = 0;
        m_stall = 0; m_full = 0;
    endtask

    function automatic int stidx(input bit [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return -1;
        endcase
    endfunction

    task automatic step(input bit dv, input bit [1:0] st, input bit sr, input bit rw,
                        input bit af, input bit bf, input bit xf, input bit cm,
                        input bit fl, input bit rs);
        int   s;
        bit   need, d, c;
        bit   fr[3];
        exp_t e;
        decValid = dv; RSstation = st; stationRequest = sr; robWrite = rw;
        aluFree = af; brFree = bf; auxFree = xf; robCommit = cm;
        flush = fl; reset = rs;

        s    = stidx(st);
        need = sr && (s >= 0);
        d    = dv && !in_flush && !fl && !rs && (!need || cred[s] > 0)
               && (!rw || count < ROB_D);
        e.disp    = d;
        e.stall   = dv && !d;
        e.tag     = (head + count) % ROB_D;
        e.err     = err;
        e.stall_n = m_stall;
        e.full_n  = m_full;
        exp_q.push_back(e);

        if (rs) begin
            model_reset();
        end else begin
            if (e.stall) m_stall++;
            if (count == ROB_D) m_full++;
            if (fl) begin
                for (int i = 0; i < 3; i++) cred[i] = dep[i];
                count = 0;
                in_flush = 1;
            end else if (in_flush) begin
                in_flush = 0;
            end else begin
                fr[0] = af; fr[1] = bf; fr[2] = xf;
                for (int i = 0; i < 3; i++) begin
                    bit a;
                    a = d && need && (s == i);
                    if (a && fr[i]) begin
                        // allocation and release cancel out
                    end else if (a) begin
                        cred[i]--;
                    end else if (fr[i]) begin
                        if (cred[i] == dep[i]) err = 1;
                        else cred[i]++;
                    end
                end
                c = cm;
                if (c && count == 0) begin
                    err = 1;
                    c = 0;
                end
                if (c) head = (head + 1) % ROB_D;
                count = count + ((d && rw) ? 1 : 0) - (c ? 1 : 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare with the head
    // of the expected-response queue.
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            check("dispatch",  64'(dispatch),  64'(m_e.disp));
            check("decStall",  64'(decStall),  64'(m_e.stall));
            check("robTag",    64'(robTag),    64'(m_e.tag));
            check("creditErr", 64'(creditErr), 64'(m_e.err));
`ifdef DISPATCH_STATS_EN
            check("stallCycles",   64'(stallCycles),   64'(m_e.stall_n));
            check("robFullCycles", 64'(robFullCycles), 64'(m_e.full_n));
`endif
        end
    end

    initial begin
        bit [1:0] st;
        model_reset();
        reset = 1; decValid = 0; RSstation = 0; stationRequest = 0; robWrite = 0;
        aluFree = 0; brFree = 0; auxFree = 0; robCommit = 0; flush = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Five ALU instructions, fifth waits for an aluFree.
        repeat (5) step(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);

        // Nine ROB writes across stations: ROB full on the ninth, then wrap.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            st = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b01 : 2'b11;
            step(1, st, 1, 1, 0, 0, 0, 0, 0, 0);
        end
        step(1, 2'b11, 1, 1, 0, 0, 0, 1, 0, 0);
        step(1, 2'b11, 1, 1, 0, 0, 0, 0, 0, 0);

        // Same-cycle allocate and release with one ALU credit left.
        do_reset();
        repeat (3) step(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);

        // Exhaust every station, then RSstation=10 still dispatches.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            st = (i < 4) ? 2'b00 : (i < 8) ? 2'b01 : 2'b11;
            step(1, st, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        step(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b10, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0);

        // Flush with robCount=5, brCred=0 and robHead=2.
        do_reset();
        repeat (4) step(1, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (2) step(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 2'b01, 1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0);

        // Release at a full aux counter: sticky error until reset.
        do_reset();
        step(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) idle();
        step(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        do_reset();
        idle();

        // Three stalled cycles after draining the ALU station.
        do_reset();
        repeat (7) step(1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Random traffic.
        do_reset();
        repeat (3000) begin
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
